// File: rtl/cache_flush_pkg.sv
// Shared types and width helpers for the cache flush sequencer.
// Pure declarations: no latency and no backpressure apply.
package cache_flush_pkg;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_READ,
        FS_CHECK,
        FS_WB,
        FS_ADV,
        FS_INVAL,
        FS_DONE
    } flush_state_t;

    // Bits needed to index n entries; a single entry still gets one bit.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of the writeback counter: it must be able to hold lines*ways.
    function automatic int cnt_w(input int lines, input int ways);
        return idx_w(lines * ways) + 1;
    endfunction

endpackage

// File: rtl/flush_walk_ctr.sv
// Set/way walk counter: way is the fast index, set advances on way wrap.
// Latency: position updates one cycle after inc/clr; no backpressure, the caller gates inc.
module flush_walk_ctr
    import cache_flush_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        inc,
    output logic [idx_w(NUMLINES)-1:0]  set_idx,
    output logic [NUMWAYS-1:0]          way_oh,
    output logic                        last
);

    localparam int SW = idx_w(NUMLINES);
    localparam int WW = idx_w(NUMWAYS);
    localparam logic [SW-1:0] LAST_SET = SW'(NUMLINES - 1);
    localparam logic [WW-1:0] LAST_WAY = WW'(NUMWAYS - 1);

    logic [WW-1:0] way_idx;

    // Both sizes are powers of two, so the natural binary wrap lands on 0/0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (clr) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (inc) begin
            way_idx <= way_idx + WW'(1);
            if (way_idx == LAST_WAY) begin
                set_idx <= set_idx + SW'(1);
            end
        end
    end

    assign last = (set_idx == LAST_SET) && (way_idx == LAST_WAY);

    always_comb begin
        way_oh          = '0;
        way_oh[way_idx] = 1'b1;
    end

endmodule

// File: rtl/cache_flush_seq.sv
// Walks every set/way writing back dirty+valid lines, then pulses a global invalidate.
// Latency: 3 cycles per line plus 1+stall per writeback, plus INVAL and DONE; WbReq holds until WbAck.
// Optional CACHE_FLUSH_STATS_EN adds the DirtyCount writeback counter output.
module cache_flush_seq
    import cache_flush_pkg::*;
#(
    parameter int NUMWAYS  = 4,
    parameter int NUMLINES = 128,
    parameter int SETLEN   = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                FlushReq,
    input  logic                InvalidateReq,
    input  logic [NUMWAYS-1:0]  DirtyWay,
    input  logic [NUMWAYS-1:0]  ValidWay,
    input  logic                WbAck,
    output logic                FlushAdrEn,
    output logic [SETLEN-1:0]   FlushAdr,
    output logic [NUMWAYS-1:0]  FlushWay,
    output logic                WbReq,
    output logic                ClearDirty,
    output logic                InvalidateCache,
    output logic                FlushBusy,
    output logic                FlushDone
`ifdef CACHE_FLUSH_STATS_EN
    ,
    output logic [cnt_w(NUMLINES, NUMWAYS)-1:0] DirtyCount
`endif
);

    flush_state_t state, state_nxt;
    logic         ctr_clr;
    logic         ctr_inc;
    logic         ctr_last;
    logic         line_hit;

    flush_walk_ctr #(
        .NUMWAYS  (NUMWAYS),
        .NUMLINES (NUMLINES)
    ) u_walk (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (ctr_clr),
        .inc     (ctr_inc),
        .set_idx (FlushAdr),
        .way_oh  (FlushWay),
        .last    (ctr_last)
    );

    // Only the way under inspection matters; the one-hot selects it.
    assign line_hit = |(DirtyWay & ValidWay & FlushWay);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ctr_clr         = 1'b0;
        ctr_inc         = 1'b0;
        FlushAdrEn      = 1'b0;
        WbReq           = 1'b0;
        ClearDirty      = 1'b0;
        InvalidateCache = 1'b0;
        FlushDone       = 1'b0;
        FlushBusy       = (state != FS_IDLE);
        unique case (state)
            FS_IDLE: begin
                // A combined request walks first; INVAL is reached at the end anyway.
                if (FlushReq) begin
                    ctr_clr   = 1'b1;
                    state_nxt = FS_READ;
                end else if (InvalidateReq) begin
                    state_nxt = FS_INVAL;
                end
            end
            FS_READ: begin
                FlushAdrEn = 1'b1;
                state_nxt  = FS_CHECK;
            end
            FS_CHECK: begin
                state_nxt = line_hit ? FS_WB : FS_ADV;
            end
            FS_WB: begin
                WbReq = 1'b1;
                if (WbAck) begin
                    ClearDirty = 1'b1;
                    state_nxt  = FS_ADV;
                end
            end
            FS_ADV: begin
                ctr_inc   = 1'b1;
                state_nxt = ctr_last ? FS_INVAL : FS_READ;
            end
            FS_INVAL: begin
                InvalidateCache = 1'b1;
                state_nxt       = FS_DONE;
            end
            FS_DONE: begin
                FlushDone = 1'b1;
                state_nxt = FS_IDLE;
            end
            default: begin
                state_nxt = FS_IDLE;
            end
        endcase
    end

`ifdef CACHE_FLUSH_STATS_EN
    // At most one writeback per line, so the extra MSB rules out overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            DirtyCount <= '0;
        end else if (ctr_clr) begin
            DirtyCount <= '0;
        end else if (ClearDirty) begin
            DirtyCount <= DirtyCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_flush_seq.sv
// Directed bench for cache_flush_seq at 4 ways x 4 sets with an array model and ack policy.
module tb_cache_flush_seq;

    localparam int NW = 4;
    localparam int NL = 4;
    localparam int SL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          FlushReq;
    logic          InvalidateReq;
    logic [NW-1:0] DirtyWay;
    logic [NW-1:0] ValidWay;
    logic          WbAck;
    logic          FlushAdrEn;
    logic [SL-1:0] FlushAdr;
    logic [NW-1:0] FlushWay;
    logic          WbReq;
    logic          ClearDirty;
    logic          InvalidateCache;
    logic          FlushBusy;
    logic          FlushDone;
`ifdef CACHE_FLUSH_STATS_EN
    logic [4:0]    DirtyCount;
`endif

    logic [NW-1:0] dirty_mem [NL];
    logic [NW-1:0] valid_mem [NL];

    assign DirtyWay = dirty_mem[FlushAdr];
    assign ValidWay = valid_mem[FlushAdr];

    always #5 clk = ~clk;

    cache_flush_seq #(
        .NUMWAYS  (NW),
        .NUMLINES (NL),
        .SETLEN   (SL)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .FlushReq        (FlushReq),
        .InvalidateReq   (InvalidateReq),
        .DirtyWay        (DirtyWay),
        .ValidWay        (ValidWay),
        .WbAck           (WbAck),
        .FlushAdrEn      (FlushAdrEn),
        .FlushAdr        (FlushAdr),
        .FlushWay        (FlushWay),
        .WbReq           (WbReq),
        .ClearDirty      (ClearDirty),
        .InvalidateCache (InvalidateCache),
        .FlushBusy       (FlushBusy),
        .FlushDone       (FlushDone)
`ifdef CACHE_FLUSH_STATS_EN
        ,
        .DirtyCount      (DirtyCount)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    int ack_delay, wb_run;
    int n_adren, n_wb, n_clr, n_inval, inval_k, done_k, wraps, wb_bad, first_adr;
    int exp_wb_adr, exp_wb_way;
    logic [SL-1:0] prev_adr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_adren = 0; n_wb = 0; n_clr = 0; n_inval = 0;
        inval_k = 0; done_k = 0; wraps = 0; wb_bad = 0; first_adr = -1;
        wb_run = 0;
        prev_adr = FlushAdr;
    endtask

    // One cycle: observe at the falling edge, answer WbReq, then observe the ack-dependent outputs.
    task automatic step_obs(input int k);
        @(negedge clk);
        if (WbReq) begin
            WbAck = (wb_run == ack_delay);
            wb_run++;
            n_wb++;
            if (FlushAdr != SL'(exp_wb_adr) || FlushWay != NW'(exp_wb_way)) wb_bad++;
        end else begin
            WbAck  = 1'b0;
            wb_run = 0;
        end
        #1;
        if (FlushAdrEn) begin
            n_adren++;
            if (first_adr < 0) first_adr = int'(FlushAdr);
        end
        if (ClearDirty) n_clr++;
        if (InvalidateCache) begin
            n_inval++;
            inval_k = k;
        end
        if (FlushDone) done_k = k;
        if (prev_adr == 2'd3 && FlushAdr == 2'd0) wraps++;
        prev_adr = FlushAdr;
    endtask

    // Request cycle counts as cycle 0; done_k is the cycle FlushDone is high.
    task automatic run_pass(input logic fr, input logic ir, input int mid_k);
        @(negedge clk);
        #1;
        clear_stats();
        FlushReq      = fr;
        InvalidateReq = ir;
        for (int k = 1; k <= 400; k++) begin
            step_obs(k);
            FlushReq      = (k == mid_k);
            InvalidateReq = 1'b0;
            if (done_k != 0) break;
        end
        FlushReq = 1'b0;
    endtask

    task automatic fill_mem(input logic [NW-1:0] d, input logic [NW-1:0] v);
        for (int s = 0; s < NL; s++) begin
            dirty_mem[s] = d;
            valid_mem[s] = v;
        end
    endtask

    initial begin
        reset = 1'b0; FlushReq = 1'b0; InvalidateReq = 1'b0; WbAck = 1'b0;
        ack_delay = 0; exp_wb_adr = 0; exp_wb_way = 0;
        fill_mem('0, '1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_adr", FlushAdr, 0);
        chk("rst_way", FlushWay, 1);
        chk("rst_busy", FlushBusy, 0);
        chk("rst_pulses", {FlushAdrEn, WbReq, ClearDirty, InvalidateCache, FlushDone}, 0);
        reset = 1'b1;

        // 1: clean cache
        run_pass(1'b1, 1'b0, 0);
        chk("t1_adren", n_adren, 16);
        chk("t1_wbreq", n_wb, 0);
        chk("t1_inval", n_inval, 1);
        chk("t1_done_cyc", done_k, 50);
        chk("t1_wraps", wraps, 1);

        // 2: set 2 way 3 dirty, ack after 3 low cycles
        dirty_mem[2] = 4'b1000;
        ack_delay = 3; exp_wb_adr = 2; exp_wb_way = 8;
        run_pass(1'b1, 1'b0, 0);
        chk("t2_wb_cycles", n_wb, 4);
        chk("t2_wb_addr_bad", wb_bad, 0);
        chk("t2_clr", n_clr, 1);
        chk("t2_done_cyc", done_k, 54);
`ifdef CACHE_FLUSH_STATS_EN
        chk("t2_dirtycount", DirtyCount, 1);
`endif

        // 3a: dirty but not valid
        fill_mem('0, '1);
        dirty_mem[1] = 4'b0100;
        valid_mem[1] = 4'b1011;
        run_pass(1'b1, 1'b0, 0);
        chk("t3_no_wb", n_wb, 0);
        chk("t3_done_cyc", done_k, 50);

        // 4: both requests together, stray FlushReq mid-walk
        fill_mem('0, '1);
        run_pass(1'b1, 1'b1, 10);
        chk("t4_adren", n_adren, 16);
        chk("t4_inval", n_inval, 1);
        chk("t4_done_cyc", done_k, 50);
        step_obs(0);
        step_obs(0);
        chk("t4_idle_after", FlushBusy, 0);

        // 5: reset during a stalled writeback at set 1
        dirty_mem[1] = 4'b0001;
        ack_delay = 1000; exp_wb_adr = 1; exp_wb_way = 1;
        @(negedge clk);
        #1;
        clear_stats();
        FlushReq = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step_obs(k);
            FlushReq = 1'b0;
            if (WbReq) break;
        end
        chk("t5_in_wb", WbReq, 1);
        chk("t5_wb_adr", FlushAdr, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_adr", FlushAdr, 0);
        chk("t5_rst_way", FlushWay, 1);
        chk("t5_rst_outs", {FlushAdrEn, WbReq, ClearDirty, InvalidateCache, FlushDone, FlushBusy}, 0);
        WbAck = 1'b0; wb_run = 0;
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        for (int k = 1; k <= 3; k++) step_obs(k);
        chk("t5_idle_busy", FlushBusy, 0);
        chk("t5_idle_pulses", n_adren + n_wb + n_inval + done_k, 0);
        fill_mem('0, '1);
        run_pass(1'b1, 1'b0, 0);
        chk("t5_first_adr", first_adr, 0);
        chk("t5_done_cyc", done_k, 50);

        // 6: every line dirty, ack immediately
        fill_mem('1, '1);
        ack_delay = 0;
        @(negedge clk);
        #1;
        clear_stats();
        FlushReq = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            exp_wb_adr = int'(FlushAdr);
            exp_wb_way = int'(FlushWay);
            step_obs(k);
            FlushReq = 1'b0;
            if (done_k != 0) break;
        end
        chk("t6_wb", n_wb, 16);
        chk("t6_clr", n_clr, 16);
        chk("t6_wb_stable", wb_bad, 0);
        chk("t6_done_cyc", done_k, 66);
        chk("t6_wraps", wraps, 1);
        chk("t6_end_adr", FlushAdr, 0);
`ifdef CACHE_FLUSH_STATS_EN
        chk("t6_dirtycount", DirtyCount, 16);
`endif

        // 3b: invalidate-only pass
        run_pass(1'b0, 1'b1, 0);
        chk("t3b_adren", n_adren, 0);
        chk("t3b_inval_cyc", inval_k, 1);
        chk("t3b_done_cyc", done_k, 2);
        chk("t3b_inval", n_inval, 1);
`ifdef CACHE_FLUSH_STATS_EN
        chk("t3b_dirtycount_kept", DirtyCount, 16);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
